pkt_wr_ctrl: RTL and testbench

Write-side pointer controller for the dual-clock FIFO, successor to the basic write controller. It adds packet mode (speculative writes, commit on last word, drop/rollback, oversize discard), a programmable almost-full flag and overflow reporting. It runs entirely in the write clock domain. It consumes the read pointer already synchronised into this domain and publishes a registered Gray write pointer for the read side. In stream mode it behaves as a plain write controller, with the new flags added.

---
 rtl/pkt_wr_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pkt_wr_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_wr_ctrl.sv
// pkt_wr_ctrl
// Write-side pointer controller for a dual-clock FIFO, running entirely in
// the write clock domain. Supports packet mode (speculative writes that are
// committed on the last word, drop/rollback of the open packet, discard of
// packets that can never fit) or plain stream mode. It also produces a
// programmable almost-full flag and overflow reporting.
//
// Ports
//   wr_clk         : write-domain clock
//   rst_n          : synchronous active-low reset
//   wr_en          : a word is presented
//   wr_last        : presented word closes the packet (packet mode)
//   wr_drop        : abort the open packet (packet mode)
//   rd_ptr_wsync   : read pointer, Gray, already synchronised to wr_clk
//   wr_we          : RAM write strobe (combinational)
//   wr_addr        : RAM write address (low bits of the speculative pointer)
//   wr_ptr         : committed write pointer, Gray, registered, to read side
//   wr_full        : FIFO full, counted against the speculative pointer
//   wr_almost_full : occupancy >= AF_THRESH
//   fifo_cnt       : speculative occupancy
//   overflow       : one-cycle pulse after a write attempt while full
//   pkt_oversize   : one-cycle pulse when a packet is found to exceed DEPTH
module pkt_wr_ctrl #(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter bit PKT_MODE  = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          wr_clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          wr_last,
    input  logic          wr_drop,
    input  logic [AW:0]   rd_ptr_wsync,
    output logic          wr_we,
    output logic [AW-1:0] wr_addr,
    output logic [AW:0]   wr_ptr,
    output logic          wr_full,
    output logic          wr_almost_full,
    output logic [AW:0]   fifo_cnt,
    output logic          overflow,
    output logic          pkt_oversize
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_W    = (AW+1)'(AF_THRESH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW:0]   spec_reg, spec_next;
    logic [AW:0]   cmt_reg, cmt_next;
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   fifo_cnt_reg;
    logic          wr_full_reg;
    logic          wr_almost_full_reg;
    logic          overflow_reg;
    logic          pkt_oversize_reg;
    logic          oversize_next;

    logic [AW:0]   rd_bin;
    logic [AW:0]   spec_inc;
    logic [AW:0]   cnt_next;
    logic          drop;
    logic          discarding;
    logic          acc;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= AW; gi++) begin : g_rd_bin
            assign rd_bin[gi] = ^rd_ptr_wsync[AW:gi];
        end
    endgenerate

    // Drop has no meaning in stream mode, so it is masked out entirely there.
    assign drop       = PKT_MODE && wr_drop;
    assign discarding = (state_reg == DISCARD);
    // While discarding nothing reaches the RAM, so full must not stall the sink.
    assign acc        = wr_en && !drop && (!wr_full_reg || discarding);
    assign wr_we      = rst_n && acc && !discarding;
    assign wr_addr    = spec_reg[AW-1:0];
    assign spec_inc   = spec_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        spec_next     = spec_reg;
        cmt_next      = cmt_reg;
        oversize_next = 1'b0;
        if (!PKT_MODE) begin
            state_next = IDLE;
            if (acc) begin
                spec_next = spec_inc;
                cmt_next  = spec_inc;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (acc) begin
                        spec_next = spec_inc;
                        if (wr_last) begin
                            cmt_next = spec_inc;
                        end else begin
                            state_next = OPEN;
                        end
                    end
                end
                OPEN: begin
                    if (drop) begin
                        spec_next  = cmt_reg;
                        state_next = IDLE;
                    end else if (acc) begin
                        if (wr_last) begin
                            spec_next  = spec_inc;
                            cmt_next   = spec_inc;
                            state_next = IDLE;
                        end else if ((spec_inc - cmt_reg) == DEPTH_W) begin
                            // Packet fills the whole FIFO without ending: it can
                            // never commit, so roll back and sink the remainder.
                            spec_next     = cmt_reg;
                            oversize_next = 1'b1;
                            state_next    = DISCARD;
                        end else begin
                            spec_next = spec_inc;
                        end
                    end
                end
                DISCARD: begin
                    if (drop || (wr_en && wr_last)) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Occupancy is measured from the speculative pointer so open packets
    // reserve their space; modulo arithmetic keeps it correct through wrap.
    assign cnt_next = spec_next - rd_bin;

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            spec_reg           <= '0;
            cmt_reg            <= '0;
            wr_ptr_reg         <= '0;
            fifo_cnt_reg       <= '0;
            wr_full_reg        <= 1'b0;
            wr_almost_full_reg <= 1'b0;
            overflow_reg       <= 1'b0;
            pkt_oversize_reg   <= 1'b0;
        end else begin
            state_reg          <= state_next;
            spec_reg           <= spec_next;
            cmt_reg            <= cmt_next;
            wr_ptr_reg         <= cmt_next ^ (cmt_next >> 1);
            fifo_cnt_reg       <= cnt_next;
            wr_full_reg        <= (cnt_next == DEPTH_W);
            wr_almost_full_reg <= (cnt_next >= AF_W);
            overflow_reg       <= wr_en && wr_full_reg;
            pkt_oversize_reg   <= oversize_next;
        end
    end

    assign wr_ptr         = wr_ptr_reg;
    assign fifo_cnt       = fifo_cnt_reg;
    assign wr_full        = wr_full_reg;
    assign wr_almost_full = wr_almost_full_reg;
    assign overflow       = overflow_reg;
    assign pkt_oversize   = pkt_oversize_reg;

endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// Testbench for pkt_wr_ctrl: a stream-mode and a packet-mode instance
// (DEPTH=8, AF_THRESH=6) run in lock-step on shared stimulus and are checked
// every cycle against a word-count reference model, plus directed anchors.
`timescale 1ns/1ps
module tb_pkt_wr_ctrl;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, wr_last, wr_drop;
    logic [3:0] rd_ptr_wsync;

    logic       o_we   [2];
    logic [2:0] o_addr [2];
    logic [3:0] o_ptr  [2];
    logic       o_full [2];
    logic       o_af   [2];
    logic [3:0] o_cnt  [2];
    logic       o_ovf  [2];
    logic       o_ovs  [2];

    always #5 clk = ~clk;

    pkt_wr_ctrl #(.DEPTH(8), .AF_THRESH(6), .PKT_MODE(1'b0)) u_str (
        .wr_clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_last(wr_last),
        .wr_drop(wr_drop), .rd_ptr_wsync(rd_ptr_wsync),
        .wr_we(o_we[0]), .wr_addr(o_addr[0]), .wr_ptr(o_ptr[0]),
        .wr_full(o_full[0]), .wr_almost_full(o_af[0]), .fifo_cnt(o_cnt[0]),
        .overflow(o_ovf[0]), .pkt_oversize(o_ovs[0])
    );

    pkt_wr_ctrl #(.DEPTH(8), .AF_THRESH(6), .PKT_MODE(1'b1)) u_pkt (
        .wr_clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_last(wr_last),
        .wr_drop(wr_drop), .rd_ptr_wsync(rd_ptr_wsync),
        .wr_we(o_we[1]), .wr_addr(o_addr[1]), .wr_ptr(o_ptr[1]),
        .wr_full(o_full[1]), .wr_almost_full(o_af[1]), .fifo_cnt(o_cnt[1]),
        .overflow(o_ovf[1]), .pkt_oversize(o_ovs[1])
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: unbounded word counts. Index 0 = stream, 1 = packet.
    int m_spec [2];   // words written (speculatively) so far
    int m_cmt  [2];   // words committed so far
    int m_rd;         // words consumed by the reader
    bit m_full [2];   // full as seen after the last edge
    bit m_disc;       // packet instance is sinking an oversize packet
    bit e_ovf  [2];
    bit e_ovs;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit en, input bit last, input bit drop);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_spec[k] = 0; m_cmt[k] = 0; m_full[k] = 1'b0; e_ovf[k] = 1'b0;
            end
            m_disc = 1'b0;
            e_ovs  = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) e_ovf[k] = en && m_full[k];
            // stream: every accepted word is committed at once
            if (en && !m_full[0]) begin
                m_spec[0]++;
                m_cmt[0] = m_spec[0];
            end
            // packet
            e_ovs = 1'b0;
            if (m_disc) begin
                if (drop || (en && last)) m_disc = 1'b0;
            end else if (drop) begin
                m_spec[1] = m_cmt[1];
            end else if (en && !m_full[1]) begin
                if (last) begin
                    m_spec[1]++;
                    m_cmt[1] = m_spec[1];
                end else if (m_spec[1] + 1 - m_cmt[1] == D) begin
                    m_spec[1] = m_cmt[1];
                    m_disc    = 1'b1;
                    e_ovs     = 1'b1;
                end else begin
                    m_spec[1]++;
                end
            end
            for (int k = 0; k < 2; k++) m_full[k] = ((m_spec[k] - m_rd) == D);
        end
    endtask

    // One clock cycle: drive at negedge, check strobe/address before the
    // edge, check registered outputs just after it.
    task automatic step(input bit en, input bit last, input bit drop);
        bit ew;
        int cnt;
        wr_en = en; wr_last = last; wr_drop = drop;
        rd_ptr_wsync = gray4(m_rd);
        #1;
        for (int k = 0; k < 2; k++) begin
            ew = rst_n && en && !m_full[k] && (k == 0 || (!drop && !m_disc));
            chk($sformatf("wr_we[%0d]", k), 32'(o_we[k]), 32'(ew));
            if (rst_n) chk($sformatf("wr_addr[%0d]", k), 32'(o_addr[k]), 32'(m_spec[k] % D));
        end
        model_edge(en, last, drop);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cnt = m_spec[k] - m_rd;
            chk($sformatf("fifo_cnt[%0d]", k), 32'(o_cnt[k]), 32'(cnt & 15));
            chk($sformatf("wr_full[%0d]", k), 32'(o_full[k]), 32'(cnt == D));
            chk($sformatf("almost_full[%0d]", k), 32'(o_af[k]), 32'(cnt >= 6));
            chk($sformatf("wr_ptr[%0d]", k), 32'(o_ptr[k]), 32'(gray4(m_cmt[k])));
            chk($sformatf("overflow[%0d]", k), 32'(o_ovf[k]), 32'(e_ovf[k]));
            chk($sformatf("oversize[%0d]", k), 32'(o_ovs[k]), 32'((k == 1) ? e_ovs : 1'b0));
        end
        $display("cyc rst_n=%0b en=%0b last=%0b drop=%0b rd=%0d | str cnt=%0d ptr=%0h | pkt cnt=%0d ptr=%0h",
                 rst_n, en, last, drop, m_rd, o_cnt[0], o_ptr[0], o_cnt[1], o_ptr[1]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_rd  = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);   // wr_en during reset must not write
        rst_n = 1'b1;
    endtask

    logic [3:0] gray_tab [9];
    logic [3:0] ptr_tab  [3];
    bit         prev_msb;
    int         toggles;
    bit         r_en, r_last, r_drop;
    int         min_cmt;

    initial begin
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        ptr_tab  = '{4'h0, 4'h0, 4'h2};
        rst_n = 1'b0; wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0;
        rd_ptr_wsync = '0;
        m_rd = 0; m_disc = 1'b0; e_ovs = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_spec[k] = 0; m_cmt[k] = 0; m_full[k] = 1'b0; e_ovf[k] = 1'b0;
        end
        @(negedge clk);
        do_reset();
        chk("rst_ptr", 32'(o_ptr[1]), 32'h0);
        chk("rst_cnt", 32'(o_cnt[0]), 32'h0);

        // Fill: stream reaches full; the packet instance sees a 12-word
        // packet that overflows DEPTH and is discarded.
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, (i == 12), 1'b0);
            if (i <= 8) chk("fill_ptr", 32'(o_ptr[0]), 32'(gray_tab[i]));
            if (i == 5) chk("af_before", 32'(o_af[0]), 32'h0);
            if (i == 6) chk("af_at6", 32'(o_af[0]), 32'h1);
            if (i == 7) chk("full_before", 32'(o_full[0]), 32'h0);
            if (i == 8) chk("full_at8", 32'(o_full[0]), 32'h1);
            if (i == 8) chk("oversize_at8", 32'(o_ovs[1]), 32'h1);
            if (i == 8) chk("ovf_at8", 32'(o_ovf[0]), 32'h0);
            if (i == 9) chk("oversize_pulse", 32'(o_ovs[1]), 32'h0);
            if (i == 9) chk("ovf_at9", 32'(o_ovf[0]), 32'h1);
            if (i == 12) chk("discard_cnt", 32'(o_cnt[1]), 32'h0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_clear", 32'(o_ovf[0]), 32'h0);

        // 3-word packet
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, (i == 3), 1'b0);
            chk("pkt3_ptr", 32'(o_ptr[1]), 32'(ptr_tab[i-1]));
            chk("pkt3_cnt", 32'(o_cnt[1]), 32'(i));
        end

        // 2 words then drop with wr_en high
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("drop_cnt", 32'(o_cnt[1]), 32'h0);
        chk("drop_addr", 32'(o_addr[1]), 32'h0);
        chk("drop_ptr", 32'(o_ptr[1]), 32'h0);
        chk("drop_ignored_stream", 32'(o_cnt[0]), 32'h3);

        // Wrap: 20 single-word commits, reader 2 behind
        do_reset();
        toggles  = 0;
        prev_msb = o_ptr[0][3];
        for (int i = 0; i < 20; i++) begin
            m_rd = (i > 0) ? i - 1 : 0;
            step(1'b1, 1'b1, 1'b0);
            if (o_ptr[0][3] != prev_msb) toggles++;
            prev_msb = o_ptr[0][3];
            if (i >= 1) chk("wrap_cnt", 32'(o_cnt[0]), 32'h2);
            chk("wrap_full", 32'(o_full[1]), 32'h0);
        end
        chk("wrap_msb_toggles", 32'(toggles), 32'h2);

        // Reset while a packet is open
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("midrst_cnt", 32'(o_cnt[1]), 32'h0);
        chk("midrst_ptr", 32'(o_ptr[1]), 32'h0);
        rst_n = 1'b1;
        chk("midrst_addr", 32'(o_addr[1]), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("midrst_commit", 32'(o_ptr[1]), 32'h1);

        // Randomised traffic with a reader that never passes committed data
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r_en   = ($urandom_range(0, 9) < 7);
            r_last = ($urandom_range(0, 3) == 0);
            r_drop = ($urandom_range(0, 19) == 0);
            min_cmt = (m_cmt[0] < m_cmt[1]) ? m_cmt[0] : m_cmt[1];
            if (m_rd < min_cmt && $urandom_range(0, 1) == 1) m_rd++;
            step(r_en, r_last, r_drop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
